alu_req_arbiter: RTL and testbench

Shares one combinational `ALU` instance among `NREQ` requesters. Each request carries two operands and a 5-bit ALU opcode. The block grants requesters round-robin, drives registered operands into the shared ALU, captures the result and returns it with the requester ID over a valid/ready response channel. It sits between client datapaths and the `ALU`; no requester drives the `ALU` directly.

---
 rtl/alu_req_arbiter.sv | 150 +++++++++++++++
 tb/tb_alu_req_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: round-robin sharing of one combinational ALU among NREQ
// requesters, with registered ALU operands and a valid/ready response channel.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for a request; grants one requester combinationally
// EXEC  | registered operands drive the ALU; result captured on the edge
// RESP  | response presented; held until the consumer accepts it
module alu_req_arbiter #(
    parameter  int WIDTH = 32,
    parameter  int NREQ  = 4,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ*5-1:0]     req_sel,
    output logic [WIDTH-1:0]      alu_a,
    output logic [WIDTH-1:0]      alu_b,
    output logic [4:0]            alu_sel,
    input  logic [WIDTH-1:0]      alu_f,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_data,
    output logic [IDW-1:0]        rsp_id,
    output logic [15:0]           ops_done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [4:0]       alu_sel_q, alu_sel_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic [15:0]      ops_done_q, ops_done_d;

    logic             grant_found;
    logic [IDW-1:0]   grant_idx;
    logic [IDW-1:0]   ptr_next;
    logic [NREQ-1:0]  req_ready_c;
    logic             rsp_valid_c;

    // Round-robin search: scan offsets from the top down so the smallest
    // offset from ptr (the highest-priority requester) is the last writer.
    always_comb begin
        int             idx;
        logic [IDW-1:0] idx_v;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = int'(ptr_q) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            idx_v = IDW'(idx);
            if (req_valid[idx_v]) begin
                grant_found = 1'b1;
                grant_idx   = idx_v;
            end
        end
    end

    // Pointer moves one past the requester just served, modulo NREQ.
    always_comb begin
        ptr_next = '0;
        if (rsp_id_q != IDW'(NREQ - 1)) ptr_next = rsp_id_q + IDW'(1);
    end

    // Next-state and datapath-register updates.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_sel_d   = alu_sel_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        ops_done_d  = ops_done_q;
        req_ready_c = '0;
        rsp_valid_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_found) begin
                    req_ready_c[grant_idx] = 1'b1;
                    alu_a_d   = req_a[grant_idx*WIDTH +: WIDTH];
                    alu_b_d   = req_b[grant_idx*WIDTH +: WIDTH];
                    alu_sel_d = req_sel[grant_idx*5 +: 5];
                    rsp_id_d  = grant_idx;
                    state_d   = ST_EXEC;
                end
            end
            ST_EXEC: begin
                rsp_data_d = alu_f;
                state_d    = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid_c = 1'b1;
                if (rsp_ready) begin
                    ops_done_d = ops_done_q + 16'd1;
                    ptr_d      = ptr_next;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any in-flight op.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_sel_q  <= '0;
            rsp_data_q <= '0;
            rsp_id_q   <= '0;
            ops_done_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_sel_q  <= alu_sel_d;
            rsp_data_q <= rsp_data_d;
            rsp_id_q   <= rsp_id_d;
            ops_done_q <= ops_done_d;
        end
    end

    // Handshake outputs are forced low while reset is held, even with
    // requests pending.
    assign req_ready = rst ? '0 : req_ready_c;
    assign rsp_valid = rsp_valid_c & ~rst;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sel   = alu_sel_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign ops_done  = ops_done_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed testbench for alu_req_arbiter with a small combinational ALU model.
module tb_alu_req_arbiter;

    localparam int WIDTH = 32;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;

    logic                  clk;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ*5-1:0]     req_sel;
    logic [WIDTH-1:0]      alu_a;
    logic [WIDTH-1:0]      alu_b;
    logic [4:0]            alu_sel;
    logic [WIDTH-1:0]      alu_f;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [WIDTH-1:0]      rsp_data;
    logic [IDW-1:0]        rsp_id;
    logic [15:0]           ops_done;

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] exp_ops  = 16'd0;

    alu_req_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_f(alu_f),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id), .ops_done(ops_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared ALU: add, subtract, xor; everything else returns 0.
    always_comb begin
        case (alu_sel)
            5'b00000: alu_f = alu_a + alu_b;
            5'b00010: alu_f = alu_a - alu_b;
            5'b10001: alu_f = alu_a ^ alu_b;
            default:  alu_f = '0;
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] sel);
        req_a[id*WIDTH +: WIDTH] = a;
        req_b[id*WIDTH +: WIDTH] = b;
        req_sel[id*5 +: 5]       = sel;
        req_valid[id]            = 1'b1;
    endtask

    // One complete transaction from requester id with immediate response accept.
    task automatic run_op(input string tag, input int id, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] sel,
                          input logic [31:0] exp);
        int n;
        set_req(id, a, b, sel);
        #1;
        n = 0;
        while (req_ready[id] !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        chk({tag, "_grant"}, 64'(req_ready), 64'(4'b0001 << id));
        tick();
        req_valid[id] = 1'b0;
        chk({tag, "_exec_ready"}, 64'(req_ready), 64'd0);
        chk({tag, "_exec_valid"}, 64'(rsp_valid), 64'd0);
        tick();
        chk({tag, "_valid"}, 64'(rsp_valid), 64'd1);
        chk({tag, "_data"}, 64'(rsp_data), 64'(exp));
        chk({tag, "_id"}, 64'(rsp_id), 64'(id));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        exp_ops = exp_ops + 16'd1;
        chk({tag, "_done_valid"}, 64'(rsp_valid), 64'd0);
        chk({tag, "_ops"}, 64'(ops_done), 64'(exp_ops));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held;
        logic        stable;
        rst       = 1'b1;
        req_valid = 4'hF;
        rsp_ready = 1'b0;
        req_a     = {4{32'hDEADBEEF}};
        req_b     = {4{32'h12345678}};
        req_sel   = {4{5'b00000}};

        // Reset held with all requests pending.
        repeat (3) tick();
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_alu_a", 64'(alu_a), 64'd0);
        chk("rst_alu_b", 64'(alu_b), 64'd0);
        chk("rst_alu_sel", 64'(alu_sel), 64'd0);
        chk("rst_rsp_data", 64'(rsp_data), 64'd0);
        chk("rst_rsp_id", 64'(rsp_id), 64'd0);
        chk("rst_ops_done", 64'(ops_done), 64'd0);

        req_valid = '0;
        req_a = '0;
        req_b = '0;
        req_sel = '0;
        rst = 1'b0;
        tick();
        chk("idle_no_req", 64'(req_ready), 64'd0);

        // ptr=0: add from 2 (ptr->3), sub from 1 (ptr->2), xor from 0 (ptr->1),
        // wrapping subtract from 3 (ptr->0).
        run_op("add", 2, 32'd5, 32'd7, 5'b00000, 32'd12);
        chk("add_alu_a", 64'(alu_a), 64'd5);
        chk("add_alu_sel", 64'(alu_sel), 64'd0);
        run_op("sub", 1, 32'd10, 32'd3, 5'b00010, 32'd7);
        run_op("xor", 0, 32'hF0F0F0F0, 32'hFFFF0000, 5'b10001, 32'h0F0FF0F0);
        run_op("wrap", 3, 32'd0, 32'd1, 5'b00010, 32'hFFFFFFFF);
        run_op("undef", 2, 32'd9, 32'd9, 5'b11111, 32'd0);
        // ptr is now 3.
        run_op("ptr3", 3, 32'd1, 32'd1, 5'b00000, 32'd2);
        // ptr is now 0.

        // Round-robin with all requesters held valid and response always accepted.
        for (int i = 0; i < NREQ; i++) set_req(i, 32'd100 + 32'(i), 32'(i), 5'b00000);
        rsp_ready = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("rr_grant", 64'(req_ready), 64'(4'b0001 << (k % 4)));
            tick();
            chk("rr_exec_ready", 64'(req_ready), 64'd0);
            tick();
            chk("rr_valid", 64'(rsp_valid), 64'd1);
            chk("rr_id", 64'(rsp_id), 64'(k % 4));
            chk("rr_data", 64'(rsp_data), 64'(100 + 2 * (k % 4)));
            tick();
            exp_ops = exp_ops + 16'd1;
        end
        req_valid = '0;
        rsp_ready = 1'b0;
        chk("rr_ops", 64'(ops_done), 64'(exp_ops));
        // ptr is now 1.

        // Backpressure: requester 0 served while requester 1 waits.
        set_req(0, 32'd40, 32'd2, 5'b00000);
        #1;
        chk("bp_grant0", 64'(req_ready), 64'b0001);
        tick();
        req_valid[0] = 1'b0;
        set_req(1, 32'd9, 32'd4, 5'b00010);
        tick();
        chk("bp_valid", 64'(rsp_valid), 64'd1);
        chk("bp_data", 64'(rsp_data), 64'd42);
        held = rsp_data;
        stable = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (rsp_valid !== 1'b1 || rsp_data !== held || rsp_id !== 2'd0 ||
                req_ready !== 4'b0000) stable = 1'b0;
        end
        chk("bp_stable", 64'(stable), 64'd1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        exp_ops = exp_ops + 16'd1;
        chk("bp_ops", 64'(ops_done), 64'(exp_ops));
        chk("bp_grant1", 64'(req_ready), 64'b0010);
        tick();
        req_valid[1] = 1'b0;
        tick();
        chk("bp1_valid", 64'(rsp_valid), 64'd1);
        chk("bp1_data", 64'(rsp_data), 64'd5);
        chk("bp1_id", 64'(rsp_id), 64'd1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        exp_ops = exp_ops + 16'd1;
        chk("bp1_ops", 64'(ops_done), 64'(exp_ops));

        // Reset asserted while a response is pending.
        set_req(2, 32'd3, 32'd3, 5'b00000);
        #1;
        chk("mr_grant", 64'(req_ready), 64'b0100);
        tick();
        tick();
        chk("mr_valid_pre", 64'(rsp_valid), 64'd1);
        rst = 1'b1;
        #1;
        chk("mr_valid", 64'(rsp_valid), 64'd0);
        chk("mr_ready", 64'(req_ready), 64'd0);
        chk("mr_ops", 64'(ops_done), 64'd0);
        chk("mr_data", 64'(rsp_data), 64'd0);
        tick();
        rst = 1'b0;
        exp_ops = 16'd0;
        #1;
        // First cycle out of reset grants the still-pending requester.
        chk("mr_regrant", 64'(req_ready), 64'b0100);
        tick();
        req_valid[2] = 1'b0;
        tick();
        chk("mr_reissue_data", 64'(rsp_data), 64'd6);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        exp_ops = exp_ops + 16'd1;
        chk("mr_reissue_ops", 64'(ops_done), 64'(exp_ops));

        // Counter wrap: preset to 0xFFFF while idle, then complete one op.
        force dut.ops_done_q = 16'hFFFF;
        tick();
        release dut.ops_done_q;
        #1;
        chk("wrap_preset", 64'(ops_done), 64'hFFFF);
        exp_ops = 16'hFFFF;
        run_op("cnt_wrap", 0, 32'd1, 32'd2, 5'b00000, 32'd3);
        chk("wrap_zero", 64'(ops_done), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
